// File: rtl/pwm_duty_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_meter_if
//  Description : Bus bundle between a PWM source/consumer and pwm_duty_meter.
//                The master side drives the enable and the PWM waveform and
//                observes the measurement results. The slave side is the
//                meter itself.
//  Signals     : en          - measurement enable (master -> slave)
//                pwm_in      - PWM waveform, synchronous to clk
//                high_cnt    - high cycles of the last measured period
//                period_cnt  - cycles of the last measured period
//                duty_pct    - floor(high_cnt*100/period_cnt), 0..100
//                valid       - one-cycle pulse when duty_pct is updated
//                stuck       - last report was a timeout
//                overrun     - sticky, a period was dropped (divider busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_meter_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [6:0]       duty_pct;
    logic             valid;
    logic             stuck;
    logic             overrun;

    modport master (
        output en,
        output pwm_in,
        input  high_cnt,
        input  period_cnt,
        input  duty_pct,
        input  valid,
        input  stuck,
        input  overrun
    );

    modport slave (
        input  en,
        input  pwm_in,
        output high_cnt,
        output period_cnt,
        output duty_pct,
        output valid,
        output stuck,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_meter
//  Description : Measures a clk-synchronous PWM waveform. For every complete
//                period it reports the high time, the period and the integer
//                duty cycle in percent, computed by a 7-step restoring
//                divider. A line without rising edges for TIMEOUT cycles is
//                reported once as 0 % or 100 % with the stuck flag set.
//  Ports       : clk  - sole clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - pwm_duty_meter_if.slave (en, pwm_in in; high_cnt,
//                       period_cnt, duty_pct, valid, stuck, overrun out)
//  Parameters  : CNT_W   - width of high/period counters
//                TIMEOUT - cycles without a rising edge before a stuck
//                          report, 16 <= TIMEOUT <= 2^CNT_W-1
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pwm_duty_meter_if.slave bus
);

    // Numerator hi*100 needs 7 extra bits since 100 < 128.
    localparam int               c_num_w   = CNT_W + 7;
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [c_num_w-1:0] c_hundred = c_num_w'(100);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_s1;
    logic               r_s2;
    logic [CNT_W-1:0]   r_per_ctr;
    logic [CNT_W-1:0]   r_hi_ctr;
    logic [CNT_W-1:0]   r_high_cnt;
    logic [CNT_W-1:0]   r_period_cnt;
    logic [6:0]         r_duty_pct;
    logic               r_valid;
    logic               r_stuck;
    logic               r_overrun;

    logic               r_div_busy;
    logic [2:0]         r_div_cnt;
    logic [6:0]         r_div_quo;
    logic [c_num_w-1:0] r_div_rem;
    logic [c_num_w-1:0] r_div_den;

    logic               w_re;
    logic [CNT_W-1:0]   w_per_inc;
    logic [CNT_W-1:0]   w_hi_inc;
    logic               w_div_ge;
    logic [6:0]         w_to_duty;
    logic [CNT_W-1:0]   w_to_high;

    assign w_re      = r_s1 & ~r_s2;
    assign w_per_inc = r_per_ctr + CNT_W'(1);
    assign w_hi_inc  = r_hi_ctr + CNT_W'(r_s1);
    assign w_div_ge  = (r_div_rem >= r_div_den);
    // A stuck line reports its current level as 0 % or 100 %.
    assign w_to_duty = r_s1 ? 7'd100 : 7'd0;
    assign w_to_high = r_s1 ? c_timeout : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_per_ctr    <= '0;
            r_hi_ctr     <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_duty_pct   <= '0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
            r_overrun    <= 1'b0;
            r_div_busy   <= 1'b0;
            r_div_cnt    <= '0;
            r_div_quo    <= '0;
            r_div_rem    <= '0;
            r_div_den    <= '0;
        end else begin
            r_s1    <= bus.pwm_in;
            r_s2    <= r_s1;
            r_valid <= 1'b0;

            if (!bus.en) begin
                // Disabled: abandon any division; results keep last values.
                r_state    <= ST_IDLE;
                r_per_ctr  <= '0;
                r_hi_ctr   <= '0;
                r_div_busy <= 1'b0;
                r_div_cnt  <= '0;
                r_stuck    <= 1'b0;
                r_overrun  <= 1'b0;
            end else begin
                // Restoring divider: seven compare/subtract steps, then the
                // quotient is published on the following edge.
                if (r_div_busy) begin
                    if (r_div_cnt == 3'd7) begin
                        r_duty_pct <= r_div_quo;
                        r_valid    <= 1'b1;
                        r_div_busy <= 1'b0;
                    end else begin
                        if (w_div_ge) begin
                            r_div_rem <= r_div_rem - r_div_den;
                        end
                        r_div_quo <= {r_div_quo[5:0], w_div_ge};
                        r_div_den <= r_div_den >> 1;
                        r_div_cnt <= r_div_cnt + 3'd1;
                    end
                end

                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_ARM;
                        r_per_ctr <= '0;
                        r_hi_ctr  <= '0;
                    end

                    ST_ARM: begin
                        if (w_re) begin
                            // Start of the first full period; the partial
                            // period before it is discarded.
                            r_per_ctr <= CNT_W'(1);
                            r_hi_ctr  <= CNT_W'(1);
                            r_stuck   <= 1'b0;
                            r_state   <= ST_MEAS;
                        end else if (r_per_ctr != c_timeout) begin
                            // Once saturated, no further reports until re.
                            r_per_ctr <= w_per_inc;
                            if (w_per_inc == c_timeout) begin
                                r_valid      <= 1'b1;
                                r_stuck      <= 1'b1;
                                r_duty_pct   <= w_to_duty;
                                r_period_cnt <= c_timeout;
                                r_high_cnt   <= w_to_high;
                            end
                        end
                    end

                    ST_MEAS: begin
                        if (w_re) begin
                            r_per_ctr <= CNT_W'(1);
                            r_hi_ctr  <= CNT_W'(1);
                            r_stuck   <= 1'b0;
                            if (r_div_busy) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_period_cnt <= r_per_ctr;
                                r_high_cnt   <= r_hi_ctr;
                                r_div_busy   <= 1'b1;
                                r_div_cnt    <= '0;
                                r_div_quo    <= '0;
                                r_div_rem    <= c_num_w'(r_hi_ctr) * c_hundred;
                                // Quotient < 128, so the first trial
                                // subtrahend is the period scaled by 2^6.
                                r_div_den    <= c_num_w'(r_per_ctr) << 6;
                            end
                        end else begin
                            r_per_ctr <= w_per_inc;
                            r_hi_ctr  <= w_hi_inc;
                            if (w_per_inc == c_timeout) begin
                                r_valid      <= 1'b1;
                                r_stuck      <= 1'b1;
                                r_duty_pct   <= w_to_duty;
                                r_period_cnt <= c_timeout;
                                r_high_cnt   <= w_to_high;
                                r_state      <= ST_ARM;
                            end
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.high_cnt   = r_high_cnt;
    assign bus.period_cnt = r_period_cnt;
    assign bus.duty_pct   = r_duty_pct;
    assign bus.valid      = r_valid;
    assign bus.stuck      = r_stuck;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_meter
//  Description : Self-checking bench for pwm_duty_meter. Every edge is
//                compared against an event-level reference model that works
//                from the recorded sample history (rise positions, ones
//                counts, plain division) and a queue of pending reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 300;
    localparam int HIST    = 65536;

    logic clk;
    logic rst;

    pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;
    int n_edge;
    int n_valid_seen;

    // Reference model state
    logic samp [0:HIST-1];
    int   m_high, m_period, m_duty;
    int   m_valid, m_stuck, m_overrun;
    bit   m_latched;
    bit   active, have_det, have_acc, timed_out;
    int   arm_edge, det_edge, acc_edge;
    int   q_edge [$];
    int   q_duty [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    // Event-level model of one clock edge, in terms of sample positions.
    task automatic model_edge(input logic p, input logic e, input logic r);
        int per;
        int hi;
        m_valid   = 0;
        m_latched = 0;
        if (r) begin
            samp[n_edge] = 1'b0;
            m_high = 0; m_period = 0; m_duty = 0;
            m_stuck = 0; m_overrun = 0;
            active = 0;
            q_edge.delete(); q_duty.delete();
        end else begin
            samp[n_edge] = p;
            if (!e) begin
                active = 0;
                q_edge.delete(); q_duty.delete();
                m_stuck = 0; m_overrun = 0;
            end else if (!active) begin
                active = 1; arm_edge = n_edge;
                have_det = 0; have_acc = 0; timed_out = 0;
            end else begin
                if (q_edge.size() > 0 && q_edge[0] == n_edge) begin
                    m_duty  = q_duty[0];
                    m_valid = 1;
                    void'(q_edge.pop_front());
                    void'(q_duty.pop_front());
                end
                if (samp[n_edge-1] && !samp[n_edge-2]) begin
                    m_stuck = 0;
                    if (have_det) begin
                        per = n_edge - det_edge;
                        hi  = 0;
                        for (int i = det_edge - 1; i <= n_edge - 2; i++) hi += int'(samp[i]);
                        if (have_acc && (n_edge - acc_edge) <= 8) begin
                            m_overrun = 1;
                        end else begin
                            m_high = hi; m_period = per;
                            q_edge.push_back(n_edge + 8);
                            q_duty.push_back((hi * 100) / per);
                            acc_edge = n_edge; have_acc = 1; m_latched = 1;
                        end
                    end
                    have_det = 1; det_edge = n_edge; timed_out = 0;
                end else if (!timed_out &&
                             ((have_det && (n_edge - det_edge) == TIMEOUT - 1) ||
                              (!have_det && (n_edge - arm_edge) == TIMEOUT))) begin
                    m_valid  = 1;
                    m_stuck  = 1;
                    m_duty   = samp[n_edge-1] ? 100 : 0;
                    m_high   = samp[n_edge-1] ? TIMEOUT : 0;
                    m_period = TIMEOUT;
                    timed_out = 1; have_det = 0;
                end
            end
        end
    endtask

    task automatic step(input logic p, input logic e, input logic r);
        bus.pwm_in = p;
        bus.en     = e;
        rst        = r;
        @(posedge clk);
        #1;
        n_edge++;
        if (n_edge >= HIST) begin
            $display("FAIL history: got=%0d expected<%0d", n_edge, HIST);
            $fatal(1, "history exhausted");
        end
        model_edge(p, e, r);
        if (bus.valid === 1'b1) n_valid_seen++;
        check("valid",   32'(bus.valid),      32'(m_valid));
        check("stuck",   32'(bus.stuck),      32'(m_stuck));
        check("overrun", 32'(bus.overrun),    32'(m_overrun));
        check("duty",    32'(bus.duty_pct),   32'(m_duty));
        check("high",    32'(bus.high_cnt),   32'(m_high));
        check("period",  32'(bus.period_cnt), 32'(m_period));
    endtask

    task automatic run_wave(input int h, input int l, input int cyc, input logic e);
        for (int i = 0; i < cyc; i++) step(logic'((i % (h + l)) < h), e, 1'b0);
    endtask

    task automatic run_level(input logic v, input int cyc, input logic e);
        for (int i = 0; i < cyc; i++) step(v, e, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vstart;
        int h, l, k;
        bit found;
        n_total = 0; n_bad = 0; n_edge = 0; n_valid_seen = 0;
        samp[0] = 1'b0;
        active = 0; have_det = 0; have_acc = 0; timed_out = 0;
        arm_edge = 0; det_edge = 0; acc_edge = 0;
        m_high = 0; m_period = 0; m_duty = 0; m_valid = 0; m_stuck = 0; m_overrun = 0;
        bus.en = 1'b0; bus.pwm_in = 1'b0; rst = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("rst_duty",   32'(bus.duty_pct), 0);
        check("rst_period", 32'(bus.period_cnt), 0);
        check("rst_flags",  {29'd0, bus.valid, bus.stuck, bus.overrun}, 0);

        // Short period 3/5: 8-cycle periods overrun every other edge
        run_wave(3, 5, 80, 1'b1);
        check("short_duty",    32'(bus.duty_pct), 37);
        check("short_period",  32'(bus.period_cnt), 8);
        check("short_high",    32'(bus.high_cnt), 3);
        check("short_overrun", 32'(bus.overrun), 1);

        // Generator threshold 127, counter period 256
        run_level(1'b0, 2, 1'b0);
        run_wave(127, 129, 256 * 4, 1'b1);
        check("gen50_duty",    32'(bus.duty_pct), 49);
        check("gen50_period",  32'(bus.period_cnt), 256);
        check("gen50_high",    32'(bus.high_cnt), 127);
        check("gen50_overrun", 32'(bus.overrun), 0);

        // dc=0 then dc=100: one stuck report each
        vstart = n_valid_seen;
        run_level(1'b0, 2 * TIMEOUT + 50, 1'b1);
        check("dc0_reports", n_valid_seen - vstart, 1);
        check("dc0_duty",    32'(bus.duty_pct), 0);
        check("dc0_stuck",   32'(bus.stuck), 1);
        vstart = n_valid_seen;
        run_level(1'b1, 2 * TIMEOUT + 50, 1'b1);
        check("dc100_reports", n_valid_seen - vstart, 1);
        check("dc100_duty",    32'(bus.duty_pct), 100);
        check("dc100_high",    32'(bus.high_cnt), TIMEOUT);

        // Stuck-low report, then recovery with 10/10
        run_level(1'b0, 2, 1'b0);
        run_level(1'b0, TIMEOUT + 20, 1'b1);
        check("rec_stuck_set", 32'(bus.stuck), 1);
        run_wave(10, 10, 100, 1'b1);
        check("rec_stuck_clr", 32'(bus.stuck), 0);
        check("rec_duty",      32'(bus.duty_pct), 50);
        check("rec_period",    32'(bus.period_cnt), 20);

        // Extreme duty, truncation
        run_wave(1, 199, 600, 1'b1);
        check("ext_lo_duty", 32'(bus.duty_pct), 0);
        run_wave(199, 1, 600, 1'b1);
        check("ext_hi_duty", 32'(bus.duty_pct), 99);

        // Drop en at E4 of a division
        run_level(1'b0, 2, 1'b0);
        found = 0;
        begin
            int i;
            for (i = 0; i < 200 && !found; i++) begin
                step(logic'((i % 40) < 20), 1'b1, 1'b0);
                found = m_latched;
            end
            check("abort_latch_seen", 32'(found), 1);
            vstart = n_valid_seen;
            for (int j = 0; j < 3; j++) step(logic'(((i + j) % 40) < 20), 1'b1, 1'b0);
            run_level(1'b0, 12, 1'b0);
        end
        check("abort_no_valid", n_valid_seen - vstart, 0);
        check("abort_duty_hold", 32'(bus.duty_pct), 99);
        check("abort_overrun",   32'(bus.overrun), 0);

        // Reset mid-measurement
        run_wave(7, 9, 50, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("mrst_duty",   32'(bus.duty_pct), 0);
        check("mrst_high",   32'(bus.high_cnt), 0);
        check("mrst_period", 32'(bus.period_cnt), 0);
        check("mrst_flags",  {29'd0, bus.valid, bus.stuck, bus.overrun}, 0);
        step(1'b0, 1'b0, 1'b0);

        // Randomized segments against the model
        for (int s = 0; s < 40; s++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                run_level(logic'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0);
            end else if (k == 1) begin
                run_level(logic'($urandom_range(0, 1)), $urandom_range(50, 400), 1'b1);
            end else begin
                h = $urandom_range(1, 30);
                l = $urandom_range(1, 30);
                run_wave(h, l, (h + l) * $urandom_range(2, 6), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
